// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - ID/EX/MEM hazard and redirect signals plus pipeline control outputs
interface hazard_stall_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_uses_rt;
    logic              ex_is_load;
    logic [ADDR_W-1:0] ex_dst;
    logic              id_is_jump;
    logic              mem_branch_taken;
    logic              stall_pipeline;
    logic              pc_write_en;
    logic              ifid_write_en;
    logic              flush_ifid;
    logic              flush_idex;
    logic              busy;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_is_load, ex_dst, id_is_jump, mem_branch_taken,
        input  stall_pipeline, pc_write_en, ifid_write_en, flush_ifid, flush_idex, busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_is_load, ex_dst, id_is_jump, mem_branch_taken,
        output stall_pipeline, pc_write_en, ifid_write_en, flush_ifid, flush_idex, busy
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use stall and branch/jump flush sequencer (optional HAZARD_PERF_CNT_EN counters)
module hazard_stall_ctrl #(
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 3,
    parameter int ADDR_W              = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_ctrl_if.slave   bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_flushes
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // The cycle that detects a hazard or branch is itself the first bubble/flush
    // cycle, so the counter holds the number of extra cycles after the current one.
    localparam bit       LOAD_MULTI  = (LOAD_STALL_CYCLES > 1);
    localparam bit       FLUSH_MULTI = (BRANCH_FLUSH_CYCLES > 1);
    localparam logic [2:0] LOAD_LOAD  = LOAD_MULTI  ? 3'(LOAD_STALL_CYCLES - 2)   : 3'd0;
    localparam logic [2:0] FLUSH_LOAD = FLUSH_MULTI ? 3'(BRANCH_FLUSH_CYCLES - 2) : 3'd0;

    state_t            state;
    state_t            state_n;
    logic [2:0]        cnt;
    logic [2:0]        cnt_n;

    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic [ADDR_W-1:0] ex_dst;
    logic              hazard;

    logic              stall;
    logic              pc_we;
    logic              ifid_we;
    logic              fl_ifid;
    logic              fl_idex;

    assign id_rs  = bus.id_rs;
    assign id_rt  = bus.id_rt;
    assign ex_dst = bus.ex_dst;

    // Load in EX writing a register the ID instruction reads; r0 is hardwired zero.
    assign hazard = bus.ex_is_load && (ex_dst != '0) &&
                    ((ex_dst == id_rs) || (bus.id_uses_rt && (ex_dst == id_rt)));

    // State and counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and outputs; a taken branch overrides everything in every state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        fl_ifid = 1'b0;
        fl_idex = 1'b0;

        if (bus.mem_branch_taken) begin
            fl_ifid = 1'b1;
            fl_idex = 1'b1;
            stall   = (state != RUN);
            state_n = FLUSH_MULTI ? FLUSH : RUN;
            cnt_n   = FLUSH_LOAD;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        stall   = 1'b1;
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        if (LOAD_MULTI) begin
                            state_n = LSTALL;
                            cnt_n   = LOAD_LOAD;
                        end
                    end else if (bus.id_is_jump) begin
                        fl_ifid = 1'b1;
                    end
                end
                LSTALL: begin
                    stall   = 1'b1;
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    if (cnt == 3'd0) begin
                        state_n = RUN;
                    end else begin
                        cnt_n = cnt - 3'd1;
                    end
                end
                FLUSH: begin
                    stall   = 1'b1;
                    fl_ifid = 1'b1;
                    fl_idex = 1'b1;
                    if (cnt == 3'd0) begin
                        state_n = RUN;
                    end else begin
                        cnt_n = cnt - 3'd1;
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = 3'd0;
                end
            endcase
        end
    end

    assign bus.stall_pipeline = stall;
    assign bus.pc_write_en    = pc_we;
    assign bus.ifid_write_en  = ifid_we;
    assign bus.flush_ifid     = fl_ifid;
    assign bus.flush_idex     = fl_idex;
    assign bus.busy           = (state != RUN);

`ifdef HAZARD_PERF_CNT_EN
    // Saturating counts of pure stall bubbles and of taken-branch flush entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flushes      <= 32'd0;
        end else begin
            if (stall && !fl_idex && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (bus.mem_branch_taken && (perf_flushes != 32'hFFFF_FFFF)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    hazard_stall_ctrl_if #(.ADDR_W(5)) bus1 ();
    hazard_stall_ctrl_if #(.ADDR_W(5)) bus3 ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall1, perf_flush1, perf_stall3, perf_flush3;
`endif

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_CYCLES(3), .ADDR_W(5)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall1),
        .perf_flushes      (perf_flush1)
`endif
    );

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(3), .ADDR_W(5)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall3),
        .perf_flushes      (perf_flush3)
`endif
    );

    // Observed vectors: {stall, pc_we, ifid_we, flush_ifid, flush_idex, busy}
    logic [5:0] o1, o3;
    assign o1 = {bus1.stall_pipeline, bus1.pc_write_en, bus1.ifid_write_en,
                 bus1.flush_ifid, bus1.flush_idex, bus1.busy};
    assign o3 = {bus3.stall_pipeline, bus3.pc_write_en, bus3.ifid_write_en,
                 bus3.flush_ifid, bus3.flush_idex, bus3.busy};

    localparam logic [5:0] IDLE   = 6'b011000;
    localparam logic [5:0] HAZ    = 6'b100000;
    localparam logic [5:0] LST    = 6'b100001;
    localparam logic [5:0] JMP    = 6'b011100;
    localparam logic [5:0] BR_RUN = 6'b011110;
    localparam logic [5:0] FLS    = 6'b111111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive1(input logic br, input logic ld, input logic [4:0] dst,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses, input logic jmp);
        bus1.mem_branch_taken = br;
        bus1.ex_is_load       = ld;
        bus1.ex_dst           = dst;
        bus1.id_rs            = rs;
        bus1.id_rt            = rt;
        bus1.id_uses_rt       = uses;
        bus1.id_is_jump       = jmp;
    endtask

    task automatic drive3(input logic br, input logic ld, input logic [4:0] dst,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses, input logic jmp);
        bus3.mem_branch_taken = br;
        bus3.ex_is_load       = ld;
        bus3.ex_dst           = dst;
        bus3.id_rs            = rs;
        bus3.id_rt            = rt;
        bus3.id_uses_rt       = uses;
        bus3.id_is_jump       = jmp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive1(0, 0, 0, 0, 0, 0, 0);
        drive3(0, 0, 0, 0, 0, 0, 0);
        #1;
        tests_run++;
        if (o1 !== IDLE) begin
            $display("FAIL reset_dut1: got %b want %b", o1, IDLE);
            tests_failed++;
        end
        tests_run++;
        if (o3 !== IDLE) begin
            $display("FAIL reset_dut3: got %b want %b", o3, IDLE);
            tests_failed++;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [5:0] exp_v [2] = '{HAZ, IDLE};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) drive1(0, 1, 5, 5, 0, 0, 0);
            else        drive1(0, 0, 0, 0, 0, 0, 0);
            #1;
            tests_run++;
            if (o1 !== exp_v[i]) begin
                $display("FAIL load_use c%0d: got %b want %b", i, o1, exp_v[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_no_hazard();
        logic [5:0] exp_v [4] = '{IDLE, IDLE, HAZ, IDLE};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            case (i)
                0: drive1(0, 1, 0, 0, 0, 1, 0);
                1: drive1(0, 1, 7, 3, 7, 0, 0);
                2: drive1(0, 1, 7, 3, 7, 1, 0);
                default: drive1(0, 0, 7, 3, 7, 1, 0);
            endcase
            #1;
            tests_run++;
            if (o1 !== exp_v[i]) begin
                $display("FAIL no_hazard c%0d: got %b want %b", i, o1, exp_v[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_jump();
        logic [5:0] exp_v [4] = '{JMP, HAZ, JMP, IDLE};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            case (i)
                0: drive1(0, 0, 0, 0, 0, 0, 1);
                1: drive1(0, 1, 9, 9, 0, 0, 1);
                2: drive1(0, 0, 9, 9, 0, 0, 1);
                default: drive1(0, 0, 0, 0, 0, 0, 0);
            endcase
            #1;
            tests_run++;
            if (o1 !== exp_v[i]) begin
                $display("FAIL jump c%0d: got %b want %b", i, o1, exp_v[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] exp_v [4] = '{BR_RUN, FLS, FLS, IDLE};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive1((i == 0), 0, 0, 0, 0, 0, 0);
            #1;
            tests_run++;
            if (o1 !== exp_v[i]) begin
                $display("FAIL branch c%0d: got %b want %b", i, o1, exp_v[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_v [5] = '{BR_RUN, FLS, FLS, FLS, IDLE};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive1((i < 2), 0, 0, 0, 0, 0, 0);
            #1;
            tests_run++;
            if (o1 !== exp_v[i]) begin
                $display("FAIL branch_restart c%0d: got %b want %b", i, o1, exp_v[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_hazard_in_flush();
        logic [5:0] exp_v [5] = '{BR_RUN, FLS, FLS, HAZ, IDLE};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0)      drive1(1, 0, 0, 0, 0, 0, 0);
            else if (i < 4)  drive1(0, 1, 4, 4, 0, 0, 0);
            else             drive1(0, 0, 0, 0, 0, 0, 0);
            #1;
            tests_run++;
            if (o1 !== exp_v[i]) begin
                $display("FAIL hazard_in_flush c%0d: got %b want %b", i, o1, exp_v[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_long_stall();
        logic [5:0] exp_v [4] = '{HAZ, LST, LST, IDLE};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 1) drive3(0, 1, 6, 6, 0, 0, 0);
            else       drive3(0, 0, 0, 0, 0, 0, 0);
            #1;
            tests_run++;
            if (o3 !== exp_v[i]) begin
                $display("FAIL long_stall c%0d: got %b want %b", i, o3, exp_v[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        drive3(0, 1, 6, 6, 0, 0, 0);
        @(negedge clk);
        drive3(0, 0, 0, 0, 0, 0, 0);
        #1;
        tests_run++;
        if (o3 !== LST) begin
            $display("FAIL mid_stall_pre_rst: got %b want %b", o3, LST);
            tests_failed++;
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (o3 !== IDLE) begin
            $display("FAIL async_rst_outputs: got %b want %b", o3, IDLE);
            tests_failed++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (o3 !== IDLE) begin
            $display("FAIL post_rst_no_bubble: got %b want %b", o3, IDLE);
            tests_failed++;
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive1(0, 1, 5, 5, 0, 0, 0);
        @(negedge clk);
        drive1(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive1(0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        #1;
        tests_run++;
        if (perf_stall1 !== 32'd1) begin
            $display("FAIL perf_stall_cycles: got %0d want 1", perf_stall1);
            tests_failed++;
        end
        tests_run++;
        if (perf_flush1 !== 32'd1) begin
            $display("FAIL perf_flushes: got %0d want 1", perf_flush1);
            tests_failed++;
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_jump();
        test_branch();
        test_back_to_back();
        test_hazard_in_flush();
        test_long_stall();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
